// File: rtl/two_digit_counter_top.sv
// -----------------------------------------------------------------------------
// two_digit_counter_top
//
// Two-digit decimal counter (00..99) with a programmable power-of-two
// prescaler and a two-position multiplexed seven-segment display driver.
//
// Ports:
//   top_port_clk         in   1  system clock, rising edge
//   top_port_rst         in   1  asynchronous active-low reset of all state
//   top_port_clk_rst     in   1  synchronous active-high prescaler clear
//   top_port_clk_factor  in   5  prescaler exponent, tick every 2^factor clocks
//   top_port_ssd         out  7  active-low segments, bit0 = a .. bit6 = g
//   top_port_an          out  8  active-low anodes, bit0 = ones, bit1 = tens
//
// Parameters:
//   SIZE          width of each BCD digit register (>= 4, upper bits stay 0)
//   REFRESH_BITS  width of the display refresh counter, MSB selects the digit
//
// Contents: tdc_prescaler, tdc_bcd_counter, tdc_seg_decode, tdc_scan and the
// top-level wrapper.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// tdc_prescaler
//   Free-running 32-bit counter. tick is high when the low `factor` bits of
//   the counter are all ones, giving one tick every 2^factor clocks.
//
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          synchronous clear; loads 0 and suppresses tick
//   factor       exponent, 0 gives a tick every cycle
//   tick         count enable for the digit counter
// -----------------------------------------------------------------------------
module tdc_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [4:0] factor,
    output logic       tick
);

    logic [31:0] pre;
    logic [31:0] mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= 32'd0;
        end else if (clr) begin
            pre <= 32'd0;
        end else begin
            pre <= pre + 32'd1;
        end
    end

    // factor = 0 yields an empty mask, so the compare is trivially true and
    // the tick fires every cycle. A factor change is seen on the very next
    // edge because the compare uses the current pre value.
    always_comb begin
        mask = (32'd1 << factor) - 32'd1;
        tick = !clr && ((pre & mask) == mask);
    end

endmodule

// -----------------------------------------------------------------------------
// tdc_bcd_counter
//   Two cascaded BCD digits, advanced by tick, wrapping 99 -> 00.
//
//   clk, rst_n   clock and asynchronous active-low reset
//   tick         advance enable
//   ones, tens   current digit values (bits above [3:0] always 0)
// -----------------------------------------------------------------------------
module tdc_bcd_counter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    output logic [SIZE-1:0] ones,
    output logic [SIZE-1:0] tens
);

    localparam logic [SIZE-1:0] DIGIT_ZERO = '0;
    localparam logic [SIZE-1:0] DIGIT_ONE  = SIZE'(1);
    localparam logic [SIZE-1:0] DIGIT_NINE = SIZE'(9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= DIGIT_ZERO;
            tens <= DIGIT_ZERO;
        end else if (tick) begin
            if (ones == DIGIT_NINE) begin
                ones <= DIGIT_ZERO;
                if (tens == DIGIT_NINE) begin
                    tens <= DIGIT_ZERO;
                end else begin
                    tens <= tens + DIGIT_ONE;
                end
            end else begin
                ones <= ones + DIGIT_ONE;
            end
        end
    end

endmodule

// -----------------------------------------------------------------------------
// tdc_seg_decode
//   BCD digit to active-low seven-segment pattern (bit6 = g .. bit0 = a).
//   Any value above 9 blanks the display.
//
//   digit   value to show
//   seg     active-low segment pattern
// -----------------------------------------------------------------------------
module tdc_seg_decode #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] digit,
    output logic [6:0]      seg
);

    always_comb begin
        seg = 7'b1111111;
        if (digit <= SIZE'(9)) begin
            case (digit[3:0])
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// -----------------------------------------------------------------------------
// tdc_scan
//   Free-running refresh counter; its MSB alternates between the ones and
//   tens positions. Anode and segment outputs are pure decodes of registered
//   state so they follow reset immediately.
//
//   clk, rst_n   clock and asynchronous active-low reset
//   ones, tens   digits to display
//   ssd          active-low segments of the selected digit
//   an           active-low anodes, only bit0 or bit1 ever low
// -----------------------------------------------------------------------------
module tdc_scan #(
    parameter int SIZE         = 4,
    parameter int REFRESH_BITS = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] ones,
    input  logic [SIZE-1:0] tens,
    output logic [6:0]      ssd,
    output logic [7:0]      an
);

    logic [REFRESH_BITS-1:0] refresh;
    logic                    sel;
    logic [SIZE-1:0]         shown;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
        end
    end

    assign sel = refresh[REFRESH_BITS-1];

    always_comb begin
        if (sel) begin
            shown = tens;
            an    = 8'b1111_1101;
        end else begin
            shown = ones;
            an    = 8'b1111_1110;
        end
    end

    tdc_seg_decode #(
        .SIZE (SIZE)
    ) u_decode (
        .digit (shown),
        .seg   (ssd)
    );

endmodule

// -----------------------------------------------------------------------------
// two_digit_counter_top
//   Board-level wrapper: prescaler -> BCD counter -> display scan.
// -----------------------------------------------------------------------------
module two_digit_counter_top #(
    parameter int SIZE         = 4,
    parameter int REFRESH_BITS = 17
) (
    input  logic       top_port_clk,
    input  logic       top_port_rst,
    input  logic       top_port_clk_rst,
    input  logic [4:0] top_port_clk_factor,
    output logic [6:0] top_port_ssd,
    output logic [7:0] top_port_an
);

    logic            tick;
    logic [SIZE-1:0] ones;
    logic [SIZE-1:0] tens;

    tdc_prescaler u_prescaler (
        .clk    (top_port_clk),
        .rst_n  (top_port_rst),
        .clr    (top_port_clk_rst),
        .factor (top_port_clk_factor),
        .tick   (tick)
    );

    tdc_bcd_counter #(
        .SIZE (SIZE)
    ) u_counter (
        .clk   (top_port_clk),
        .rst_n (top_port_rst),
        .tick  (tick),
        .ones  (ones),
        .tens  (tens)
    );

    tdc_scan #(
        .SIZE         (SIZE),
        .REFRESH_BITS (REFRESH_BITS)
    ) u_scan (
        .clk   (top_port_clk),
        .rst_n (top_port_rst),
        .ones  (ones),
        .tens  (tens),
        .ssd   (top_port_ssd),
        .an    (top_port_an)
    );

endmodule

// File: tb/tb_two_digit_counter_top.sv
// -----------------------------------------------------------------------------
// tb_two_digit_counter_top
//   Directed bench for two_digit_counter_top with REFRESH_BITS = 2, so the
//   display alternates ones/tens every two clocks and both digits are seen
//   after every few edges. Expected count values are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_two_digit_counter_top;

    localparam int RB = 2;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_rst = 1'b0;
    logic [4:0] factor = 5'd0;
    logic [6:0] ssd;
    logic [7:0] an;

    always #5 clk = ~clk;

    two_digit_counter_top #(
        .SIZE         (4),
        .REFRESH_BITS (RB)
    ) dut (
        .top_port_clk        (clk),
        .top_port_rst        (rst),
        .top_port_clk_rst    (clk_rst),
        .top_port_clk_factor (factor),
        .top_port_ssd        (ssd),
        .top_port_an         (an)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] rcnt  = 2'd0;   // expected refresh counter value

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed an,ssd=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the display against an expected count value and the expected
    // refresh phase.
    task automatic show_chk(input string tag, input int val);
        logic [7:0] exp_an;
        logic [6:0] exp_ssd;
        if (rcnt[RB-1]) begin
            exp_an  = 8'b1111_1101;
            exp_ssd = seg_of(val / 10);
        end else begin
            exp_an  = 8'b1111_1110;
            exp_ssd = seg_of(val % 10);
        end
        cmp(tag, {an, ssd}, {exp_an, exp_ssd});
    endtask

    // One clock edge, then check on the falling edge.
    task automatic edge_chk(input string tag, input int val);
        @(posedge clk);
        if (rst) rcnt = rcnt + 2'd1;
        @(negedge clk);
        show_chk(tag, val);
    endtask

    // Enter reset at a falling edge, hold two edges, release at a falling edge.
    task automatic do_reset(input logic [4:0] f);
        @(negedge clk);
        rst     = 1'b0;
        clk_rst = 1'b0;
        factor  = f;
        rcnt    = 2'd0;
        #1;
        show_chk("reset_enter", 0);
        edge_chk("reset_hold", 0);
        edge_chk("reset_hold", 0);
        rst = 1'b1;
    endtask

    initial begin
        // 1. reset held for 5 clocks with factor 0
        rst     = 1'b0;
        factor  = 5'd0;
        clk_rst = 1'b0;
        #1;
        show_chk("por", 0);
        for (int i = 0; i < 5; i++) edge_chk("por_hold", 0);

        // 2. factor 0: count every edge, 99 -> 00 wrap on edge 100
        rst = 1'b1;
        for (int e = 1; e <= 99; e++) edge_chk("f0_count", e);
        edge_chk("f0_wrap", 0);
        edge_chk("f0_after_wrap", 1);

        // 3. factor 3: increments on edges 8, 16, ...; 04 after 39, 05 after 40
        do_reset(5'd3);
        for (int e = 1; e <= 40; e++) edge_chk("f3_count", e / 8);

        // 4. factor 2 with a 20-cycle prescaler clear after 3 edges
        //    (the 4th edge would have ticked; the clear suppresses it)
        do_reset(5'd2);
        for (int e = 1; e <= 3; e++) edge_chk("f2_pre", 0);
        clk_rst = 1'b1;
        for (int e = 1; e <= 20; e++) edge_chk("f2_clear", 0);
        clk_rst = 1'b0;
        for (int e = 1; e <= 9; e++) edge_chk("f2_resume", e / 4);

        // 5. factor 0: count to 57, then asynchronous reset between edges
        do_reset(5'd0);
        for (int e = 1; e <= 57; e++) edge_chk("f0_to57", e);
        #2;
        rst  = 1'b0;
        rcnt = 2'd0;
        #1;
        show_chk("async_rst", 0);
        edge_chk("async_hold", 0);
        rst = 1'b1;
        edge_chk("async_resume", 1);
        edge_chk("async_resume", 2);

        // 6. factor change mid-run: factor 2 for 2 edges (pre = 2), then
        //    factor 1 ticks when pre = 3 (edge 4) and pre = 5 (edge 6)
        do_reset(5'd2);
        edge_chk("fchg_pre", 0);
        edge_chk("fchg_pre", 0);
        factor = 5'd1;
        edge_chk("fchg_e3", 0);
        edge_chk("fchg_e4", 1);
        edge_chk("fchg_e5", 1);
        edge_chk("fchg_e6", 2);

        // 7. factor 0 with clear asserted: tick forced low, count holds
        factor = 5'd0;
        edge_chk("f0_run", 3);
        clk_rst = 1'b1;
        edge_chk("f0_clr_hold", 3);
        edge_chk("f0_clr_hold", 3);
        edge_chk("f0_clr_hold", 3);
        clk_rst = 1'b0;
        edge_chk("f0_clr_release", 4);
        edge_chk("f0_clr_release", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
